// File: rtl/hvac_scheduler.sv
// hvac_scheduler: hysteresis thermostat FSM with minimum run time, lockout and sticky sensor fault.
module hvac_scheduler #(
    parameter int MIN_RUN = 8,
    parameter int LOCKOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       temp_valid,
    input  logic [4:0] temperature,
    input  logic [4:0] setpoint,
    input  logic [1:0] hyst,
    output logic       heating,
    output logic       cooling,
    output logic [1:0] state,
    output logic       fault
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_HEAT = 2'b01, S_COOL = 2'b10, S_LOCK = 2'b11} state_t;
    localparam logic [7:0] RUN_LAST  = 8'(MIN_RUN - 1);
    localparam logic [7:0] RUN_MAX   = 8'(MIN_RUN);
    localparam logic [7:0] LOCK_LAST = 8'(LOCKOUT - 1);
    state_t     state_q, state_d;
    logic [7:0] run_q, run_d, lock_q, lock_d;
    logic       fault_q, fault_d, heating_q, cooling_q;
    logic [5:0] t6, sp6, hy6, sum, lo, hi;
    logic       fault_smp, go;
    assign t6        = {1'b0, temperature};
    assign sp6       = {1'b0, setpoint};
    assign hy6       = {4'b0, hyst};
    assign sum       = sp6 + hy6;
    assign lo        = sp6 > hy6 ? sp6 - hy6 : 6'd0;
    assign hi        = sum > 6'd31 ? 6'd31 : sum;
    assign fault_smp = temp_valid && (temperature == 5'd0 || temperature == 5'd31);
    assign go        = enable && !fault_q && !fault_smp && temp_valid;
    always_comb begin
        state_d = state_q;
        fault_d = fault_smp | (fault_q & enable);
        case (state_q)
            S_IDLE: if (go) state_d = t6 < lo ? S_HEAT : t6 > hi ? S_COOL : S_IDLE;
            S_HEAT: if (!enable || fault_smp || (run_q >= RUN_LAST && temp_valid && t6 >= sp6)) state_d = S_LOCK;
            S_COOL: if (!enable || fault_smp || (run_q >= RUN_LAST && temp_valid && t6 <= sp6)) state_d = S_LOCK;
            S_LOCK: if (lock_q == LOCK_LAST) state_d = S_IDLE;
        endcase
        // counters restart on every state change so each run/lockout is timed from its entry edge
        run_d  = state_d != state_q ? 8'd0 : run_q == RUN_MAX ? run_q : run_q + 8'd1;
        lock_d = state_d != state_q ? 8'd0 : lock_q + 8'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= 8'd0;
            lock_q    <= 8'd0;
            fault_q   <= 1'b0;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            lock_q    <= lock_d;
            fault_q   <= fault_d;
            heating_q <= state_d == S_HEAT;
            cooling_q <= state_d == S_COOL;
        end
    end
    assign heating = heating_q;
    assign cooling = cooling_q;
    assign state   = state_q;
    assign fault   = fault_q;
endmodule

// File: tb/tb_hvac_scheduler.sv
// tb_hvac_scheduler: directed vectors feed an expectation queue; a per-edge monitor pops and compares.
module tb_hvac_scheduler;
    localparam logic [1:0] IDLE = 2'b00, HEAT = 2'b01, COOL = 2'b10, LOCK = 2'b11;
    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, temp_valid = 1'b0;
    logic [4:0] temperature = 5'd0, setpoint = 5'd20;
    logic [1:0] hyst = 2'd1;
    logic       heating, cooling, fault;
    logic [1:0] state;
    int         checks = 0, errors = 0, vec = 0;
    logic [2:0] exp_q[$];
    logic [2:0] e;

    always #5 clk = ~clk;

    hvac_scheduler #(.MIN_RUN(8), .LOCKOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .temp_valid(temp_valid),
        .temperature(temperature), .setpoint(setpoint), .hyst(hyst),
        .heating(heating), .cooling(cooling), .state(state), .fault(fault)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, vec, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic tv, input logic [4:0] t, input logic [1:0] es, input logic ef);
        @(negedge clk);
        enable      = en;
        temp_valid  = tv;
        temperature = t;
        exp_q.push_back({es, ef});
    endtask

    always @(posedge clk) begin
        #1;
        chk("mutex", {7'd0, heating & cooling}, 8'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vec++;
            chk("state", {6'd0, state}, {6'd0, e[2:1]});
            chk("heating", {7'd0, heating}, {7'd0, e[2:1] == HEAT});
            chk("cooling", {7'd0, cooling}, {7'd0, e[2:1] == COOL});
            chk("fault", {7'd0, fault}, {7'd0, e[0]});
        end
    end

    initial begin
        #2;
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_heat", {7'd0, heating}, 8'd0);
        chk("rst_cool", {7'd0, cooling}, 8'd0);
        chk("rst_fault", {7'd0, fault}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // heat run: lo=19, hi=21, exits only once run count reaches 7
        step(1, 1, 18, HEAT, 0);
        step(1, 1, 19, HEAT, 0);
        step(1, 1, 20, HEAT, 0);
        repeat (4) step(1, 0, 0, HEAT, 0);
        step(1, 1, 20, HEAT, 0);
        step(1, 1, 20, LOCK, 0);
        repeat (3) step(1, 1, 25, LOCK, 0);
        step(1, 1, 25, IDLE, 0);
        step(1, 1, 25, COOL, 0);
        // early cool sample ignored, then enable drop at run count 2
        step(1, 1, 20, COOL, 0);
        step(1, 0, 0, COOL, 0);
        step(0, 0, 0, LOCK, 0);
        repeat (3) step(1, 0, 0, LOCK, 0);
        step(1, 0, 0, IDLE, 0);
        step(1, 1, 25, COOL, 0);
        step(1, 0, 0, COOL, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", {6'd0, state}, 8'd0);
        chk("async_cool", {7'd0, cooling}, 8'd0);
        chk("async_fault", {7'd0, fault}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 10, HEAT, 0);
        // sensor fault aborts heat, blocks restart until enable drops
        step(1, 1, 31, LOCK, 1);
        repeat (3) step(1, 1, 10, LOCK, 1);
        step(1, 1, 10, IDLE, 1);
        step(1, 1, 10, IDLE, 1);
        step(0, 0, 0, IDLE, 0);
        step(1, 1, 10, HEAT, 0);
        step(0, 0, 0, LOCK, 0);
        repeat (3) step(1, 0, 0, LOCK, 0);
        step(1, 0, 0, IDLE, 0);
        step(1, 1, 0, IDLE, 1);
        step(0, 0, 0, IDLE, 0);
        // saturated thresholds
        setpoint = 5'd1;
        hyst     = 2'd3;
        step(1, 1, 1, IDLE, 0);
        step(1, 1, 2, IDLE, 0);
        step(1, 1, 5, COOL, 0);
        step(0, 0, 0, LOCK, 0);
        repeat (3) step(1, 0, 0, LOCK, 0);
        step(1, 0, 0, IDLE, 0);
        setpoint = 5'd30;
        step(1, 1, 30, IDLE, 0);
        step(1, 1, 27, IDLE, 0);
        step(1, 1, 26, HEAT, 0);
        repeat (2) @(negedge clk);
        chk("drain", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hvac_scheduler.md
HVAC_SCHEDULER -- requirements
Module: hvac_scheduler

Interface
REQ-001 Parameter MIN_RUN, 8, minimum cycles heating or cooling stays asserted before a normal exit; legal range 1..255.
REQ-002 Parameter LOCKOUT, 4, idle cycles forced between any run and the next run; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port enable  input  1  scheduler permitted to run heating or cooling.
REQ-006 Port temp_valid  input  1  temperature holds a new sample this cycle.
REQ-007 Port temperature  input  5  unsigned sample in degrees, 0..31.
REQ-008 Port setpoint  input  5  unsigned target temperature.
REQ-009 Port hyst  input  2  unsigned hysteresis band, 0..3.
REQ-010 Port heating  output  1  heater drive, registered.
REQ-011 Port cooling  output  1  cooler drive, registered.
REQ-012 Port state  output  2  current FSM state code.
REQ-013 Port fault  output  1  sticky sensor-fault flag, registered.

Function
REQ-014 The FSM SHALL have four states: IDLE=2'b00, HEAT=2'b01, COOL=2'b10, LOCKOUT=2'b11.
REQ-015 Thresholds SHALL use 6-bit arithmetic with saturation: lo = (setpoint>hyst) ? setpoint-hyst : 0; hi = min(setpoint+hyst, 31).
REQ-016 Decisions SHALL use temperature, setpoint and hyst as presented in a cycle with temp_valid=1; cycles with temp_valid=0 SHALL cause no threshold-based transition.
REQ-017 A sample with temp_valid=1 and temperature of 0 or 31 SHALL set fault on that edge.
REQ-018 fault SHALL stay set until reset or until a cycle with enable=0, which clears it.
REQ-019 IDLE -> HEAT when enable=1, fault=0, no fault sample this cycle, temp_valid=1, temperature<lo.
REQ-020 IDLE -> COOL when enable=1, fault=0, no fault sample this cycle, temp_valid=1, temperature>hi.
REQ-021 A run counter SHALL clear on entry to HEAT or COOL and increment each cycle in that state, saturating at MIN_RUN.
REQ-022 HEAT -> LOCKOUT when run counter>=MIN_RUN-1, temp_valid=1 and temperature>=setpoint.
REQ-023 COOL -> LOCKOUT when run counter>=MIN_RUN-1, temp_valid=1 and temperature<=setpoint.
REQ-024 HEAT or COOL -> LOCKOUT on the next edge when enable=0 or a fault sample arrives, regardless of run counter.
REQ-025 LOCKOUT SHALL last exactly LOCKOUT cycles, then go to IDLE; samples and enable are ignored during LOCKOUT except for fault setting/clearing.
REQ-026 HEAT -> COOL and COOL -> HEAT directly SHALL never occur; every run ends through LOCKOUT.
REQ-027 heating=1 iff registered state is HEAT; cooling=1 iff registered state is COOL; both SHALL change on the same edge as state.
REQ-028 heating and cooling SHALL never both be 1.
REQ-029 Latency: a qualifying sample at edge N SHALL change state/outputs at edge N; no combinational path from inputs to outputs.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, heating=0, cooling=0, fault=0, and clear both counters.
REQ-031 Reset asserted mid-run SHALL drop heating/cooling at once with no lockout; after release the FSM starts from IDLE.

Verification
REQ-032 setpoint=20, hyst=1, enable=1, sample 18 -> HEAT next edge; samples 19,20 within first 7 run cycles -> stays HEAT; sample 20 at run count 7 -> LOCKOUT, heating=0.
REQ-033 After any exit to LOCKOUT=4 -> state 2'b11 for exactly 4 cycles then IDLE; sample 25 during lockout ignored; sample 25 after -> COOL.
REQ-034 In HEAT, sample 31 -> fault=1, LOCKOUT next edge; after lockout sample 10 -> stays IDLE; enable=0 for one cycle clears fault, then sample 10 -> HEAT.
REQ-035 setpoint=1, hyst=3 -> lo=0, sample 1 never enters HEAT; setpoint=30, hyst=3 -> hi=31, no COOL possible from legal non-fault samples.
REQ-036 In COOL at run count 2, enable=0 -> LOCKOUT next edge; rst_n=0 mid-COOL -> cooling=0 asynchronously, state=IDLE.
REQ-037 Every scenario SHALL check heating&cooling==0 on every cycle and report pass/fail once at end.
